// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension unit: extension modes, skid FSM
// states and the {extended, tag, err} payload carried through the pipeline.
package imm_ext_pkg;

  // Payload field widths; the top-level OUT_WIDTH/TAG_WIDTH default to these.
  localparam int IMM_OUT_W = 32;
  localparam int IMM_TAG_W = 5;

  typedef enum logic [1:0] {
    IMM_SIGN     = 2'b00,
    IMM_ZERO     = 2'b01,
    IMM_SIGN_SHL = 2'b10,
    IMM_UPPER    = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } imm_state_e;

  typedef struct packed {
    logic [IMM_OUT_W-1:0] extended;
    logic [IMM_TAG_W-1:0] tag;
    logic                 err;
  } imm_payload_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: takes the low `width` bits of valin and
// produces the sign/zero/shifted/upper-placed result plus an illegal-width flag.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT_AMT = 2,
  parameter int WW        = $clog2(IN_WIDTH + 1)
) (
  input  logic [IN_WIDTH-1:0]  valin,
  input  logic [WW-1:0]        width,
  input  logic [1:0]           mode,
  output logic [OUT_WIDTH-1:0] extended,
  output logic                 err
);

  int                   w;
  logic                 legal;
  logic                 sign;
  logic [WW-1:0]        sign_idx;
  logic [OUT_WIDTH-1:0] val_wide;
  logic [OUT_WIDTH-1:0] zext;
  logic [OUT_WIDTH-1:0] sext;

  // NOTE: every signal written here is given a value on every path, so no
  // latch can be inferred; blocking assignments are correct in always_comb.
  always_comb begin
    w        = int'(width);
    legal    = (w >= 1) && (w <= IN_WIDTH);
    val_wide = OUT_WIDTH'(valin);
    sign_idx = width - WW'(1);
    sign     = legal ? val_wide[sign_idx] : 1'b0;
    zext     = '0;
    sext     = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      zext[i] = (i < w) ? val_wide[i] : 1'b0;
      sext[i] = (i < w) ? val_wide[i] : sign;
    end

    extended = '0;
    case (imm_mode_e'(mode))
      IMM_SIGN:     extended = sext;
      IMM_ZERO:     extended = zext;
      IMM_SIGN_SHL: extended = sext << SHIFT_AMT;
      IMM_UPPER:    extended = zext << (OUT_WIDTH - w);
      default:      extended = '0;
    endcase

    // An illegal width zeroes the result and flags this beat only.
    if (!legal) extended = '0;
    err = !legal;
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate-extension unit: combinational extension on the input
// side feeding an output register plus one skid register under valid/ready.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = IMM_OUT_W,
  parameter int SHIFT_AMT = 2,
  parameter int TAG_WIDTH = IMM_TAG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          valin,
  input  logic [$clog2(IN_WIDTH+1)-1:0] width,
  input  logic [1:0]                   mode,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         extended,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         err
);

  imm_state_e   state_q, state_d;
  imm_payload_t or_q, or_d;
  imm_payload_t sk_q, sk_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  imm_payload_t in_payload;
  logic [OUT_WIDTH-1:0] core_ext;
  logic                 core_err;
  logic                 in_xfer;
  logic                 out_xfer;

  imm_ext_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT_AMT (SHIFT_AMT)
  ) u_core (
    .valin    (valin),
    .width    (width),
    .mode     (mode),
    .extended (core_ext),
    .err      (core_err)
  );

  always_comb begin
    in_payload          = '0;
    in_payload.extended = core_ext;
    in_payload.tag      = in_tag;
    in_payload.err      = core_err;
  end

  // Handshakes use only registered ready/valid, so out_ready never reaches in_ready.
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          or_d    = in_payload;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          sk_d    = in_payload;
          state_d = ST_TWO;
        end else if (in_xfer && out_xfer) begin
          or_d    = in_payload;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          or_d    = sk_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // NOTE: the payload registers are reset along with the control state
  // because extended/out_tag/err must read zero during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      or_q        <= '0;
      sk_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      or_q        <= or_d;
      sk_q        <= sk_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign extended  = or_q.extended;
  assign out_tag   = or_q.tag;
  assign err       = or_q.err;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed extension cases, skid
// ordering, randomized back-pressure against a queue model, and async reset.
module tb_imm_extend_unit;

  localparam int IW = 16;
  localparam int OW = 32;
  localparam int TW = 5;
  localparam int WW = $clog2(IW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] valin;
  logic [WW-1:0] width;
  logic [1:0]    mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] extended;
  logic [TW-1:0] out_tag;
  logic          err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [OW-1:0] ext;
    logic [TW-1:0] tag;
    logic          err;
  } beat_t;

  beat_t sb[$];

  imm_extend_unit #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_AMT(2), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .valin     (valin),
    .width     (width),
    .mode      (mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .extended  (extended),
    .out_tag   (out_tag),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the field value.
  function automatic beat_t model(input logic [IW-1:0] v, input int w, input int m,
                                  input logic [TW-1:0] t);
    beat_t  b;
    longint f, s;
    b.tag = t;
    if (w < 1 || w > IW) begin
      b.ext = '0;
      b.err = 1'b1;
      return b;
    end
    b.err = 1'b0;
    f = longint'(v) & ((64'sd1 <<< w) - 1);
    s = (f >= (64'sd1 <<< (w - 1))) ? f - (64'sd1 <<< w) : f;
    case (m)
      0:       b.ext = 32'(s);
      1:       b.ext = 32'(f);
      2:       b.ext = 32'(s * 4);
      default: b.ext = 32'(f * (64'sd1 <<< (OW - w)));
    endcase
    return b;
  endfunction

  task automatic drive(input logic [IW-1:0] v, input int w, input int m, input logic [TW-1:0] t);
    valin  = v;
    width  = WW'(w);
    mode   = 2'(m);
    in_tag = t;
  endtask

  // One beat with out_ready=1; checks 1-cycle latency and the result.
  task automatic one_beat(input string nm, input logic [IW-1:0] v, input int w, input int m,
                          input logic [TW-1:0] t, input logic [OW-1:0] exp_ext, input logic exp_err);
    @(negedge clk);
    drive(v, w, m, t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_ext"}, 64'(extended), 64'(exp_ext));
    check({nm, "_tag"}, 64'(out_tag), 64'(t));
    check({nm, "_err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    check({nm, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int     popped;
    int     cycles;
    beat_t  h;
    logic   will_in, will_out;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive('0, 0, 0, '0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ext", 64'(extended), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset = 1'b0;

    // Directed extension cases with hand-computed results.
    one_beat("sign10",  16'h0200, 10, 0, 5'h01, 32'hFFFF_FE00, 1'b0);
    one_beat("zero10",  16'h0200, 10, 1, 5'h02, 32'h0000_0200, 1'b0);
    one_beat("shl10",   16'h03FF, 10, 2, 5'h03, 32'hFFFF_FFFC, 1'b0);
    one_beat("upper16", 16'hABCD, 16, 3, 5'h04, 32'hABCD_0000, 1'b0);
    one_beat("w0",      16'hFFFF, 0,  0, 5'h13, 32'h0,         1'b1);
    one_beat("w17",     16'hFFFF, 17, 0, 5'h13, 32'h0,         1'b1);
    one_beat("legal",   16'h0005, 4,  0, 5'h07, 32'h0000_0005, 1'b0);
    one_beat("sign16",  16'h8000, 16, 0, 5'h08, 32'hFFFF_8000, 1'b0);
    one_beat("upper1",  16'h0001, 1,  3, 5'h09, 32'h8000_0000, 1'b0);

    // Skid ordering: beats 1,2,3 with back-pressure after beat 1.
    @(negedge clk);
    drive(16'd1, 16, 1, 5'd1); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    drive(16'd2, 16, 1, 5'd2); out_ready = 1'b0;
    check("skid_ready_b2", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(16'd3, 16, 1, 5'd3);
    check("skid_ready_two", 64'(in_ready), 64'd0);
    check("skid_head1", 64'(extended), 64'd1);
    @(negedge clk);
    check("skid_hold_ready", 64'(in_ready), 64'd0);
    check("skid_hold_ext", 64'(extended), 64'd1);
    check("skid_hold_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("skid_out2_v", 64'(out_valid), 64'd1);
    check("skid_out2", 64'(extended), 64'd2);
    check("skid_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("skid_out3_v", 64'(out_valid), 64'd1);
    check("skid_out3", 64'(extended), 64'd3);
    check("skid_out3_tag", 64'(out_tag), 64'd3);
    @(negedge clk);
    check("skid_empty", 64'(out_valid), 64'd0);

    // Randomized: continuous in_valid, random out_ready, queue model.
    popped = 0;
    cycles = 0;
    sb.delete();
    while (popped < 1000 && cycles < 20000) begin
      drive(IW'($urandom), int'($urandom_range(0, IW + 1)), int'($urandom_range(0, 3)),
            TW'($urandom));
      in_valid  = 1'b1;
      out_ready = $urandom_range(0, 1) == 1;
      #1;
      check("rnd_in_ready", 64'(in_ready), 64'(sb.size() < 2));
      check("rnd_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      will_in  = in_valid && in_ready;
      will_out = out_valid && out_ready;
      if (out_valid && sb.size() != 0) begin
        h = sb[0];
        check("rnd_ext", 64'(extended), 64'(h.ext));
        check("rnd_tag", 64'(out_tag), 64'(h.tag));
        check("rnd_err", 64'(err), 64'(h.err));
      end
      if (will_out && sb.size() != 0) begin
        void'(sb.pop_front());
        popped++;
      end
      if (will_in) sb.push_back(model(valin, int'(width), int'(mode), in_tag));
      cycles++;
      @(negedge clk);
    end
    check("rnd_completed", 64'(popped >= 1000), 64'd1);

    // Drain, then fill to TWO and reset asynchronously mid-cycle.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    drive(16'h1234, 16, 1, 5'h0A); in_valid = 1'b1;
    @(negedge clk);
    drive(16'h5678, 16, 1, 5'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_two", 64'(in_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_ext", 64'(extended), 64'd0);
    check("arst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    one_beat("post_rst", 16'h0003, 2, 0, 5'h1F, 32'hFFFF_FFFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
